dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive granted accesses per owner while the other port waits (range 1..15).
REQ-002 Parameter: AW, default 32, address width; DW, default 32, data width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 req0_i, req1_i  input  1 each  access request; port 0 = core data port, port 1 = comm engine.
REQ-006 we0_i, we1_i  input  1 each  1 = write, 0 = read.
REQ-007 addr0_i, addr1_i  input  AW each  access address.
REQ-008 wdata0_i, wdata1_i  input  DW each  write data.
REQ-009 gnt0_o, gnt1_o  output  1 each  access accepted this cycle.
REQ-010 rvalid0_o, rvalid1_o  output  1 each  read data valid for that port this cycle.
REQ-011 rdata_o  output  DW  read data, shared by both ports, qualified by rvalidN_o.
REQ-012 mem_we_o  output  1; mem_addr_o  output  AW; mem_wdata_o  output  DW; mem_rdata_i  input  DW  single-port synchronous RAM; read data appears the cycle after the address.

Function
REQ-013 FSM states: IDLE, OWN0, OWN1; 4-bit burst counter cnt; 1-bit last-served pointer lst.
REQ-014 gntN_o = (state==OWNN) & reqN_i; combinational from registered state; both grants never high together.
REQ-015 Memory driven from owner: mem_addr_o/mem_wdata_o = owner's addr/wdata; mem_we_o = gntN_o & weN_i; in IDLE mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-016 Requester holds req/we/addr/wdata stable until gnt seen; one access per granted cycle; back-to-back accesses allowed while req held.
REQ-017 Read latency: granted read in cycle N -> rvalidN_o=1 and rdata_o=mem_rdata_i in cycle N+1; rvalid is a registered 1-cycle pulse per granted read; writes produce no rvalid.
REQ-018 IDLE: single req -> that OWN next cycle; both req -> OWN of port != lst; none -> stay IDLE.
REQ-019 Latency: req rising in IDLE at cycle N -> gnt at N+1 (if req still high) -> rvalid at N+2 for a read.
REQ-020 OWNN, reqN_i low: other req high -> OWN(other) next cycle; else -> IDLE; cnt<=0; lst<=N.
REQ-021 OWNN, granted cycle: cnt increments, saturating at MAX_BURST.
REQ-022 OWNN, granted cycle with cnt==MAX_BURST-1 (or saturated) and other req high -> OWN(other) next cycle, cnt<=0, lst<=N; no idle gap.
REQ-023 OWNN, other req low: owner keeps grant indefinitely regardless of cnt.
REQ-024 Entry into any OWN state clears cnt to 0.
REQ-025 rvalid pulse of the previous owner still issues in the cycle after a switch; at most one rvalid asserted per cycle.

Reset
REQ-026 reset_i low asynchronously forces: state=IDLE, cnt=0, lst=1 (port 0 wins first tie), rvalid0_o=rvalid1_o=0, rdata_o passes mem_rdata_i but unqualified.
REQ-027 Reset during an outstanding read discards it: no rvalid after release.
REQ-028 First possible grant is the second rising edge after reset_i deasserts with req held.

Verification
REQ-029 Single read: req0=1, we0=0, addr0=0x10, RAM[0x10]=0xDEADBEEF, held until gnt -> gnt0 at N+1, rvalid0=1, rdata_o=0xDEADBEEF at N+2.
REQ-030 Tie after reset: req0=req1=1 in IDLE -> OWN0 first; after 4 granted cycles (MAX_BURST=4) -> gnt1 next cycle, no gap, gnt0 low.
REQ-031 Solo streaming: req1 held 20 cycles, req0=0 -> gnt1 high all 20 cycles, never switches.
REQ-032 Owner release: in OWN0, req0 drops with req1=1 -> gnt1 next cycle; with req1=0 -> IDLE, mem_we_o=0.
REQ-033 Write: req1=1, we1=1, addr1=0x4, wdata1=0x12345678 -> mem_we_o=1, mem_addr_o=0x4 only in gnt1 cycle, rvalid1 stays 0; readback by port 0 returns 0x12345678.
REQ-034 Reset mid-read: assert reset_i=0 in the cycle of a granted read -> rvalid0=rvalid1=0 thereafter, state IDLE, next tie goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM: core (port 0)
// and comm engine (port 1) share the RAM with bounded-burst alternation under contention.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned CW = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lst, lst_nxt;

  // lst resets to 1 so that port 0 wins the first tie
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      lst   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lst   <= lst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lst_nxt   = lst;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req0_i && req1_i) state_nxt = lst ? OWN0 : OWN1;
        else if (req0_i)      state_nxt = OWN0;
        else if (req1_i)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0_i) begin
          state_nxt = req1_i ? OWN1 : IDLE;
          cnt_nxt   = '0;
          lst_nxt   = 1'b0;
        end else if (req1_i && (cnt >= CNT_LAST)) begin
          state_nxt = OWN1;
          cnt_nxt   = '0;
          lst_nxt   = 1'b0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      OWN1: begin
        if (!req1_i) begin
          state_nxt = req0_i ? OWN0 : IDLE;
          cnt_nxt   = '0;
          lst_nxt   = 1'b1;
        end else if (req0_i && (cnt >= CNT_LAST)) begin
          state_nxt = OWN0;
          cnt_nxt   = '0;
          lst_nxt   = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign gnt0_o = (state == OWN0) && req0_i;
  assign gnt1_o = (state == OWN1) && req1_i;

  // RAM port follows the owner; parked at zero when idle
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      OWN0: begin
        mem_we_o    = gnt0_o && we0_i;
        mem_addr_o  = addr0_i;
        mem_wdata_o = wdata0_i;
      end
      OWN1: begin
        mem_we_o    = gnt1_o && we1_i;
        mem_addr_o  = addr1_i;
        mem_wdata_o = wdata1_i;
      end
      default: ;
    endcase
  end

  // Read data lands one cycle after the granted read; flag it for the issuing port
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
    end else begin
      rvalid0_o <= gnt0_o && !we0_i;
      rvalid1_o <= gnt1_o && !we1_i;
    end
  end

  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus protocol-respecting random traffic,
// checked every cycle against an owner/burst-run reference model and a shadow memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int MB = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          req0_i, req1_i, we0_i, we1_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [DW-1:0] wdata0_i, wdata1_i;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata_o(rdata_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_val(int unsigned i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // Synchronous single-port RAM; unwritten words return their preload pattern
  logic [31:0] ram [256];
  bit          written [256];
  always @(posedge clk_i) begin
    if (mem_we_o) begin
      ram[mem_addr_o[7:0]]     <= mem_wdata_o;
      written[mem_addr_o[7:0]] <= 1'b1;
    end
    mem_rdata_i <= written[mem_addr_o[7:0]] ? ram[mem_addr_o[7:0]] : init_val(32'(mem_addr_o[7:0]));
  end

  // Reference model: owner (-1 = nobody), grants in current tenure, last released owner
  int          owner, run, last;
  bit          e_rv0, e_rv1;
  logic [31:0] e_rdata;
  logic [31:0] mm [256];
  int          tests, fails;
  bit          g0_s, g1_s;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rq(int p);  return (p == 0) ? req0_i : req1_i; endfunction
  function automatic bit wev(int p); return (p == 0) ? we0_i : we1_i; endfunction
  function automatic logic [31:0] av(int p); return (p == 0) ? addr0_i : addr1_i; endfunction
  function automatic logic [31:0] dv(int p); return (p == 0) ? wdata0_i : wdata1_i; endfunction

  task automatic model_reset();
    owner = -1; run = 0; last = 1; e_rv0 = 0; e_rv1 = 0;
  endtask

  task automatic model_step();
    int g;
    logic [31:0] a;
    if (!reset_i) begin
      model_reset();
      return;
    end
    g = -1;
    if (owner >= 0 && rq(owner)) g = owner;
    e_rv0 = (g == 0) && !wev(0);
    e_rv1 = (g == 1) && !wev(1);
    if (g >= 0) begin
      a = av(g);
      if (wev(g)) mm[a[7:0]] = dv(g);
      else        e_rdata = mm[a[7:0]];
    end
    if (owner < 0) begin
      run = 0;
      if (rq(0) && rq(1)) owner = 1 - last;
      else if (rq(0))     owner = 0;
      else if (rq(1))     owner = 1;
    end else if (!rq(owner)) begin
      last  = owner;
      owner = rq(1 - owner) ? 1 - owner : -1;
      run   = 0;
    end else begin
      run++;
      if (run >= MB && rq(1 - owner)) begin
        last = owner; owner = 1 - owner; run = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit eg0, eg1, ewe;
    logic [31:0] ea, ed;
    eg0 = (owner == 0) && req0_i;
    eg1 = (owner == 1) && req1_i;
    ea  = (owner == 0) ? addr0_i  : (owner == 1) ? addr1_i  : 32'h0;
    ed  = (owner == 0) ? wdata0_i : (owner == 1) ? wdata1_i : 32'h0;
    ewe = (eg0 && we0_i) || (eg1 && we1_i);
    check("gnt0", 32'(gnt0_o), 32'(eg0));
    check("gnt1", 32'(gnt1_o), 32'(eg1));
    check("mem_we", 32'(mem_we_o), 32'(ewe));
    check("mem_addr", mem_addr_o, ea);
    check("mem_wdata", mem_wdata_o, ed);
    check("rvalid0", 32'(rvalid0_o), 32'(e_rv0));
    check("rvalid1", 32'(rvalid1_o), 32'(e_rv1));
    if (e_rv0 || e_rv1) check("rdata", rdata_o, e_rdata);
    g0_s = gnt0_o;
    g1_s = gnt1_o;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic drive(int p, bit r, bit w, logic [31:0] a, logic [31:0] d);
    if (p == 0) begin req0_i = r; we0_i = w; addr0_i = a; wdata0_i = d; end
    else        begin req1_i = r; we1_i = w; addr1_i = a; wdata1_i = d; end
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    reset_i = 1'b0;
    model_reset();
    repeat (2) cycle();
    reset_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0;
    bit sw0, sw1;
    tests = 0; fails = 0;
    for (int i = 0; i < 256; i++) mm[i] = init_val(32'(i));
    reset_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    model_reset();
    @(negedge clk_i);
    #1;
    check("reset_rvalid0", 32'(rvalid0_o), 32'h0);
    check("reset_gnt0", 32'(gnt0_o), 32'h0);
    apply_reset();

    // Single read of preloaded word
    drive(0, 1, 0, 32'h10, 0);
    n = 0;
    cycle();
    while (!g0_s && n < 10) begin cycle(); n++; end
    check("single_latency", 32'(n), 32'd1);
    drive(0, 0, 0, 0, 0);
    #1;
    check("single_rvalid0", 32'(rvalid0_o), 32'h1);
    check("single_rdata", rdata_o, 32'hDEADBEEF);
    cycle();
    cycle();

    // Tie after reset: port 0 first, MAX_BURST grants, then port 1 with no gap
    apply_reset();
    drive(0, 1, 0, 32'h20, 0);
    drive(1, 1, 0, 32'h30, 0);
    cycle();
    c0 = 0;
    for (int i = 0; i < MB; i++) begin cycle(); c0 += int'(g0_s); end
    cycle();
    sw0 = g0_s; sw1 = g1_s;
    check("tie_burst0", 32'(c0), 32'(MB));
    check("tie_switch", 32'({sw0, sw1}), 32'h1);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) cycle();

    // Solo streaming on port 1
    drive(1, 1, 0, 32'h40, 0);
    cycle();
    n = 0;
    repeat (20) begin cycle(); n += int'(g1_s); end
    check("solo_stream", 32'(n), 32'd20);
    drive(1, 0, 0, 0, 0);
    repeat (2) cycle();

    // Owner release: to waiting port, then to idle with write held but not granted
    drive(0, 1, 0, 32'h50, 0);
    repeat (2) cycle();
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 1, 32'h60, 32'hCAFE0060);
    cycle();
    cycle();
    check("release_to1", 32'(g1_s), 32'h1);
    drive(1, 0, 1, 32'h60, 32'hCAFE0060);
    cycle();
    #1;
    check("release_idle_we", 32'(mem_we_o), 32'h0);
    drive(1, 0, 0, 0, 0);
    cycle();

    // Write by port 1, readback by port 0
    drive(1, 1, 1, 32'h4, 32'h12345678);
    cycle();
    #1;
    check("wr_mem_we", 32'(mem_we_o), 32'h1);
    check("wr_mem_addr", mem_addr_o, 32'h4);
    cycle();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h4, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0);
    #1;
    check("wr_readback", rdata_o, 32'h12345678);
    check("wr_no_rvalid1", 32'(rvalid1_o), 32'h0);
    cycle();

    // Reset in the cycle of a granted read discards it
    drive(0, 1, 0, 32'h10, 0);
    cycle();
    #1;
    check("rstmid_gnt0", 32'(gnt0_o), 32'h1);
    reset_i = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0);
    cycle();
    check("rstmid_rvalid0", 32'(rvalid0_o), 32'h0);
    cycle();
    reset_i = 1'b1;
    drive(0, 1, 0, 32'h11, 0);
    drive(1, 1, 0, 32'h12, 0);
    cycle();
    cycle();
    check("rstmid_tie0", 32'(g0_s), 32'h1);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    cycle();

    // Random traffic; a waiting requester holds its request until granted
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset();
      if (!(req0_i && !g0_s))
        drive(0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      if (!(req1_i && !g1_s))
        drive(1, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
